// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 decryptor, one inverse-cipher step per clock. The cipher key is
// forward-expanded to K10 first, then the key schedule is unrolled backwards per round.
module aes_decrypt_iter (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] in,
  input  logic [127:0] decrypkey,
  output logic [127:0] out,
  output logic         busy,
  output logic         done
);

  typedef enum logic [2:0] {
    S_IDLE, S_KEYEXP, S_INIT, S_INV_SHIFT, S_INV_SUB, S_ADD_KEY, S_INV_MIX, S_DONE
  } state_e;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] ISBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  // Row-major packing: state[r][c] lives at bits 127-8*(4r+c) -: 8.
  function automatic int bi(input int r, input int c);
    return 127 - 8 * (4 * r + c);
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] x, input int r, input int c);
    return x[bi(r, c) -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    return SBOX[8 * (255 - int'(a)) +: 8];
  endfunction

  function automatic logic [7:0] isbox(input logic [7:0] a);
    return ISBOX[8 * (255 - int'(a)) +: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [127:0] inv_shift(input logic [127:0] s);
    logic [127:0] n;
    n = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        n[bi(r, c) -: 8] = gb(s, r, (c + 4 - r) % 4);
    return n;
  endfunction

  function automatic logic [127:0] inv_sub(input logic [127:0] s);
    logic [127:0] n;
    n = '0;
    for (int i = 0; i < 16; i++)
      n[127 - 8 * i -: 8] = isbox(s[127 - 8 * i -: 8]);
    return n;
  endfunction

  // 9/b/d/e multiples built from one x2,x4,x8 xtime chain per byte.
  function automatic logic [127:0] inv_mix(input logic [127:0] s);
    logic [127:0] n;
    logic [3:0][7:0] a, m9, mb, md, me;
    logic [7:0] x2, x4, x8;
    n = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        a[r]  = gb(s, r, c);
        x2    = xt(a[r]);
        x4    = xt(x2);
        x8    = xt(x4);
        m9[r] = x8 ^ a[r];
        mb[r] = x8 ^ x2 ^ a[r];
        md[r] = x8 ^ x4 ^ a[r];
        me[r] = x8 ^ x4 ^ x2;
      end
      for (int r = 0; r < 4; r++)
        n[bi(r, c) -: 8] = me[r] ^ mb[(r + 1) % 4] ^ md[(r + 2) % 4] ^ m9[(r + 3) % 4];
    end
    return n;
  endfunction

  function automatic logic [127:0] key_fwd(input logic [127:0] k, input logic [7:0] rc);
    logic [127:0] n;
    n = '0;
    for (int r = 0; r < 4; r++)
      n[bi(r, 0) -: 8] = gb(k, r, 0) ^ sbox(gb(k, (r + 1) % 4, 3)) ^ ((r == 0) ? rc : 8'h00);
    for (int c = 1; c < 4; c++)
      for (int r = 0; r < 4; r++)
        n[bi(r, c) -: 8] = gb(n, r, c - 1) ^ gb(k, r, c);
    return n;
  endfunction

  // Columns 3..1 come straight from adjacent XORs; column 0 needs the recovered column 3.
  function automatic logic [127:0] key_inv(input logic [127:0] k, input logic [7:0] rc);
    logic [127:0] n;
    n = '0;
    for (int c = 3; c > 0; c--)
      for (int r = 0; r < 4; r++)
        n[bi(r, c) -: 8] = gb(k, r, c) ^ gb(k, r, c - 1);
    for (int r = 0; r < 4; r++)
      n[bi(r, 0) -: 8] = gb(k, r, 0) ^ sbox(gb(n, (r + 1) % 4, 3)) ^ ((r == 0) ? rc : 8'h00);
    return n;
  endfunction

  state_e         state_q, state_d;
  logic [3:0]     rnd_q, rnd_d;
  logic [127:0]   key_q, key_d;
  logic [127:0]   st_q, st_d;
  logic [127:0]   out_q, out_d;
  logic [7:0]     rc;
  logic [127:0]   key_prev;

  // KEYEXP step i and ADD_KEY at rnd both use Rcon[counter+1].
  assign rc       = rcon(rnd_q + 4'd1);
  assign key_prev = key_inv(key_q, rc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_KEYEXP;
      S_KEYEXP:    if (rnd_q == 4'd9) state_d = S_INIT;
      S_INIT:      state_d = S_INV_SHIFT;
      S_INV_SHIFT: state_d = S_INV_SUB;
      S_INV_SUB:   state_d = S_ADD_KEY;
      S_ADD_KEY:   state_d = (rnd_q == 4'd0) ? S_DONE : S_INV_MIX;
      S_INV_MIX:   state_d = S_INV_SHIFT;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != S_IDLE) && (state_q != S_DONE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    rnd_d = rnd_q;
    key_d = key_q;
    st_d  = st_q;
    out_d = out_q;
    case (state_q)
      S_IDLE: if (start) begin
        st_d  = in;
        key_d = decrypkey;
        rnd_d = 4'd0;
      end
      S_KEYEXP: begin
        key_d = key_fwd(key_q, rc);
        rnd_d = rnd_q + 4'd1;
      end
      S_INIT: begin
        st_d  = st_q ^ key_q;
        rnd_d = 4'd9;
      end
      S_INV_SHIFT: st_d = inv_shift(st_q);
      S_INV_SUB:   st_d = inv_sub(st_q);
      S_ADD_KEY: begin
        key_d = key_prev;
        st_d  = st_q ^ key_prev;
        // Result is registered on the way into DONE so it is valid alongside done.
        if (rnd_q == 4'd0) out_d = st_q ^ key_prev;
        else               rnd_d = rnd_q - 4'd1;
      end
      S_INV_MIX: st_d = inv_mix(st_q);
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_q <= '0;
      key_q <= '0;
      st_q  <= '0;
      out_q <= '0;
    end else begin
      rnd_q <= rnd_d;
      key_q <= key_d;
      st_q  <= st_d;
      out_q <= out_d;
    end
  end

  assign out = out_q;

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed bench for aes_decrypt_iter, with an independent row-major AES-128 encryptor
// model (S-box derived from GF(2^8) inversion) to produce ciphertexts.
module tb_aes_decrypt_iter;

  logic         clk, rst, start, busy, done;
  logic [127:0] in, decrypkey, out;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [127:0] CT1  = 128'h696ad870c47bcdb4e004b7c5d830805a;
  localparam logic [127:0] KEY1 = 128'h0004080c0105090d02060a0e03070b0f;
  localparam logic [127:0] PT1  = 128'h004488cc115599dd2266aaee3377bbff;

  logic [7:0] sb [256];

  aes_decrypt_iter dut (
    .clk(clk), .rst(rst), .start(start), .in(in), .decrypkey(decrypkey),
    .out(out), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    for (int j = 1; j < 256; j++)
      if (gmul(a, 8'(j)) == 8'h01) return 8'(j);
    return 8'h00;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] enc(input logic [127:0] pt, input logic [127:0] key);
    logic [7:0] s [16];
    logic [7:0] t [16];
    logic [7:0] w [16];
    logic [7:0] g [4];
    logic [7:0] a [4];
    logic [7:0] rc;
    logic [127:0] res;
    for (int i = 0; i < 16; i++) begin
      w[i] = key[127 - 8 * i -: 8];
      s[i] = pt[127 - 8 * i -: 8] ^ w[i];
    end
    rc = 8'h01;
    for (int rnd = 1; rnd <= 10; rnd++) begin
      for (int r = 0; r < 4; r++) g[r] = sb[w[4 * ((r + 1) % 4) + 3]];
      g[0] = g[0] ^ rc;
      rc = xtime(rc);
      for (int r = 0; r < 4; r++) begin
        w[4 * r] = w[4 * r] ^ g[r];
        for (int c = 1; c < 4; c++) w[4 * r + c] = w[4 * r + c] ^ w[4 * r + c - 1];
      end
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          t[4 * r + c] = sb[s[4 * r + (c + r) % 4]];
      if (rnd < 10) begin
        for (int c = 0; c < 4; c++) begin
          for (int r = 0; r < 4; r++) a[r] = t[4 * r + c];
          for (int r = 0; r < 4; r++)
            t[4 * r + c] = xtime(a[r]) ^ xtime(a[(r + 1) % 4]) ^ a[(r + 1) % 4]
                           ^ a[(r + 2) % 4] ^ a[(r + 3) % 4];
        end
      end
      for (int i = 0; i < 16; i++) s[i] = t[i] ^ w[i];
    end
    res = '0;
    for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Pulse start so it is captured at edge E0; inputs are scrambled right after capture.
  // Sample index e refers to the cycle following edge E_e.
  task automatic run_op(input logic [127:0] ct, input logic [127:0] key, input int ncyc,
                        output logic [127:0] res, output int done_at,
                        output int ndone, output int nbusy);
    @(posedge clk); #1;
    start = 1'b1; in = ct; decrypkey = key;
    @(posedge clk); #1;
    start = 1'b0; in = ~ct; decrypkey = ~key;
    res = '0; done_at = -1; ndone = 0; nbusy = 0;
    for (int e = 0; e < ncyc; e++) begin
      @(negedge clk);
      if (busy) nbusy++;
      if (done) begin
        ndone++;
        if (done_at < 0) begin done_at = e; res = out; end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in = '0; decrypkey = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (out !== 128'h0) begin n_bad++; $display("FAIL reset_out: got %h want 0", out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done); end
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_fips();
    logic [127:0] res;
    int da, nd, nb;
    n_cmp++;
    if (enc(PT1, KEY1) !== CT1) begin
      n_bad++; $display("FAIL model_fips: got %h want %h", enc(PT1, KEY1), CT1);
    end
    run_op(CT1, KEY1, 56, res, da, nd, nb);
    n_cmp++; if (res !== PT1) begin n_bad++; $display("FAIL fips_out: got %h want %h", res, PT1); end
    n_cmp++; if (da !== 50) begin n_bad++; $display("FAIL fips_latency: got %0d want 50", da); end
    n_cmp++; if (nd !== 1) begin n_bad++; $display("FAIL fips_done_pulses: got %0d want 1", nd); end
    n_cmp++; if (nb !== 50) begin n_bad++; $display("FAIL fips_busy_cycles: got %0d want 50", nb); end
  endtask

  task automatic test_random();
    logic [127:0] res, pt, key;
    int da, nd, nb;
    run_op(enc(128'h0, 128'h0), 128'h0, 54, res, da, nd, nb);
    n_cmp++; if (res !== 128'h0) begin n_bad++; $display("FAIL zero_out: got %h want 0", res); end
    for (int i = 0; i < 100; i++) begin
      pt = rnd128();
      key = rnd128();
      run_op(enc(pt, key), key, 52, res, da, nd, nb);
      n_cmp++;
      if (res !== pt) begin n_bad++; $display("FAIL random_%0d: got %h want %h", i, res, pt); end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] pt [3];
    logic [127:0] ct [3];
    logic [127:0] got [3];
    int at [3];
    int k;
    for (int j = 0; j < 3; j++) begin
      pt[j] = rnd128();
      ct[j] = enc(pt[j], KEY1);
      got[j] = '0;
      at[j] = -1;
    end
    k = 0;
    @(posedge clk); #1;
    start = 1'b1; in = ct[0]; decrypkey = KEY1;
    @(posedge clk);
    for (int e = 0; e < 160; e++) begin
      #1;
      if (e == 51)       begin in = ct[1]; decrypkey = KEY1; end
      else if (e == 103) begin in = ct[2]; decrypkey = KEY1; end
      else               begin in = rnd128(); decrypkey = rnd128(); end
      @(negedge clk);
      if (done) begin
        if (k < 3) begin at[k] = e; got[k] = out; end
        k++;
      end
      @(posedge clk);
    end
    #1 start = 1'b0;
    n_cmp++; if (k !== 3) begin n_bad++; $display("FAIL b2b_count: got %0d want 3", k); end
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (at[j] !== 50 + 52 * j) begin
        n_bad++; $display("FAIL b2b_time_%0d: got %0d want %0d", j, at[j], 50 + 52 * j);
      end
      n_cmp++;
      if (got[j] !== pt[j]) begin
        n_bad++; $display("FAIL b2b_out_%0d: got %h want %h", j, got[j], pt[j]);
      end
    end
  endtask

  task automatic test_reset_midop();
    logic [127:0] res;
    int da, nd, nb;
    @(posedge clk); #1;
    start = 1'b1; in = CT1; decrypkey = KEY1;
    @(posedge clk); #1 start = 1'b0;
    repeat (24) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++; if (out !== 128'h0) begin n_bad++; $display("FAIL midrst_out: got %h want 0", out); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL midrst_done: got %b want 0", done); end
    @(posedge clk); #1 rst = 1'b0;
    run_op(CT1, KEY1, 54, res, da, nd, nb);
    n_cmp++; if (res !== PT1) begin n_bad++; $display("FAIL midrst_rerun_out: got %h want %h", res, PT1); end
    n_cmp++; if (da !== 50) begin n_bad++; $display("FAIL midrst_rerun_lat: got %0d want 50", da); end
  endtask

  task automatic test_bad_key();
    logic [127:0] res;
    int da, nd, nb;
    run_op(CT1, KEY1 ^ 128'h1, 54, res, da, nd, nb);
    n_cmp++; if (res === PT1) begin n_bad++; $display("FAIL badkey_out: got %h want anything but %h", res, PT1); end
    n_cmp++; if (da !== 50) begin n_bad++; $display("FAIL badkey_lat: got %0d want 50", da); end
  endtask

  task automatic test_hold();
    logic [127:0] res;
    int da, nd, nb;
    run_op(CT1, KEY1, 52, res, da, nd, nb);
    n_cmp++; if (res !== PT1) begin n_bad++; $display("FAIL hold_init: got %h want %h", res, PT1); end
    for (int e = 0; e < 20; e++) begin
      @(posedge clk); #1;
      start = 1'b0; in = rnd128(); decrypkey = rnd128();
      @(negedge clk);
      n_cmp++; if (out !== PT1) begin n_bad++; $display("FAIL hold_out_%0d: got %h want %h", e, out, PT1); end
      n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL hold_done_%0d: got %b want 0", e, done); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; in = '0; decrypkey = '0;
    for (int i = 0; i < 256; i++) sb[i] = affine(ginv(8'(i)));
    test_reset();
    test_fips();
    test_random();
    test_back_to_back();
    test_reset_midop();
    test_bad_key();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
